// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the instruction word layout, the jump format code and the fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] FMT_JMP = 2'b11;

    localparam int FMT_HI   = 15;
    localparam int FMT_LO   = 14;
    localparam int OP_HI    = 13;
    localparam int OP_LO    = 10;
    localparam int RD_HI    = 9;
    localparam int RD_LO    = 7;
    localparam int R1_HI    = 6;
    localparam int R1_LO    = 4;
    localparam int R2_HI    = 3;
    localparam int R2_LO    = 1;
    localparam int IMMF_BIT = 0;

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_EXT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction for one 16-bit instruction word.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] word,
    output logic [1:0]  format,
    output logic [3:0]  opcode,
    output logic [2:0]  regD,
    output logic [2:0]  reg1,
    output logic [2:0]  reg2,
    output logic [2:0]  imm,
    output logic        immFlag
);

    always_comb begin
        format  = word[FMT_HI:FMT_LO];
        opcode  = word[OP_HI:OP_LO];
        regD    = word[RD_HI:RD_LO];
        reg1    = word[R1_HI:R1_LO];
        reg2    = word[R2_HI:R2_LO];
        immFlag = word[IMMF_BIT];
        // The immediate shares the reg2 bits and only means something when flagged.
        imm     = word[IMMF_BIT] ? word[R2_HI:R2_LO] : 3'b000;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: streams words from instruction memory, joins jump words with their
// 16-bit target extension word, and presents decoded instructions one cycle after transfer.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        valid_o,
    output logic [15:0] pc_o,
    output logic [1:0]  format_o,
    output logic [3:0]  opcode_o,
    output logic [2:0]  reg1_o,
    output logic [2:0]  reg2_o,
    output logic [2:0]  regD_o,
    output logic [2:0]  imm_o,
    output logic        immFlag_o,
    output logic [15:0] jmpLoc_o
);

    fetch_state_e state_p0;
    logic [15:0]  pc_p0;
    logic         xfer_p0;

    logic [1:0] dec_format;
    logic [3:0] dec_opcode;
    logic [2:0] dec_regD;
    logic [2:0] dec_reg1;
    logic [2:0] dec_reg2;
    logic [2:0] dec_imm;
    logic       dec_immFlag;

    instr_decode u_decode (
        .word    (imem_rdata),
        .format  (dec_format),
        .opcode  (dec_opcode),
        .regD    (dec_regD),
        .reg1    (dec_reg1),
        .reg2    (dec_reg2),
        .imm     (dec_imm),
        .immFlag (dec_immFlag)
    );

    // Stage p0: request/address straight from the pc; no fetch while reset, redirecting or held.
    assign imem_addr = pc_p0;
    assign imem_req  = !rst && !redirect_i && !(valid_o && stall_i);
    assign xfer_p0   = imem_req && imem_valid;

    // Stage p1: registered instruction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0  <= FETCH_OP;
            pc_p0     <= RESET_PC;
            valid_o   <= 1'b0;
            pc_o      <= 16'h0000;
            format_o  <= 2'b00;
            opcode_o  <= 4'h0;
            reg1_o    <= 3'b000;
            reg2_o    <= 3'b000;
            regD_o    <= 3'b000;
            imm_o     <= 3'b000;
            immFlag_o <= 1'b0;
            jmpLoc_o  <= 16'h0000;
        end else if (redirect_i) begin
            pc_p0    <= redirect_pc_i;
            state_p0 <= FETCH_OP;
            valid_o  <= 1'b0;
        end else if (!(valid_o && stall_i)) begin
            if (xfer_p0) begin
                pc_p0 <= pc_p0 + 16'd1;
                unique case (state_p0)
                    FETCH_OP: begin
                        pc_o      <= pc_p0;
                        format_o  <= dec_format;
                        opcode_o  <= dec_opcode;
                        reg1_o    <= dec_reg1;
                        reg2_o    <= dec_reg2;
                        regD_o    <= dec_regD;
                        imm_o     <= dec_imm;
                        immFlag_o <= dec_immFlag;
                        if (dec_format == FMT_JMP) begin
                            // Hold the instruction back until its target word arrives.
                            state_p0 <= FETCH_EXT;
                            valid_o  <= 1'b0;
                        end else begin
                            jmpLoc_o <= 16'h0000;
                            valid_o  <= 1'b1;
                        end
                    end
                    FETCH_EXT: begin
                        jmpLoc_o <= imem_rdata;
                        valid_o  <= 1'b1;
                        state_p0 <= FETCH_OP;
                    end
                    default: state_p0 <= FETCH_OP;
                endcase
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: decode table streamed back-to-back, then jump, stall,
// redirect, wrap, memory wait and reset sequences against a simple word-addressed memory.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        valid_o;
    logic [15:0] pc_o;
    logic [1:0]  format_o;
    logic [3:0]  opcode_o;
    logic [2:0]  reg1_o;
    logic [2:0]  reg2_o;
    logic [2:0]  regD_o;
    logic [2:0]  imm_o;
    logic        immFlag_o;
    logic [15:0] jmpLoc_o;

    logic [15:0] mem [0:65535];
    int nvec;
    int nerr;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .format_o      (format_o),
        .opcode_o      (opcode_o),
        .reg1_o        (reg1_o),
        .reg2_o        (reg2_o),
        .regD_o        (regD_o),
        .imm_o         (imm_o),
        .immFlag_o     (immFlag_o),
        .jmpLoc_o      (jmpLoc_o)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  imm;
        logic        f;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Packed view of every registered output, compared as one value.
    function automatic logic [63:0] outs();
        return {12'h0, valid_o, pc_o, format_o, opcode_o, regD_o, reg1_o, reg2_o,
                imm_o, immFlag_o, jmpLoc_o};
    endfunction

    function automatic logic [63:0] exp_outs(input logic v, input logic [15:0] pc,
                                             input logic [1:0] fmt, input logic [3:0] op,
                                             input logic [2:0] rd, input logic [2:0] r1,
                                             input logic [2:0] r2, input logic [2:0] imm,
                                             input logic f, input logic [15:0] jl);
        return {12'h0, v, pc, fmt, op, rd, r1, r2, imm, f, jl};
    endfunction

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        tbl[0] = '{16'h0483, 2'd0, 4'd1,  3'd1, 3'd0, 3'd1, 3'd1, 1'b1};
        tbl[1] = '{16'h1101, 2'd0, 4'd4,  3'd2, 3'd0, 3'd0, 3'd0, 1'b1};
        tbl[2] = '{16'h8FFE, 2'd2, 4'd3,  3'd7, 3'd7, 3'd7, 3'd0, 1'b0};
        tbl[3] = '{16'h7FFF, 2'd1, 4'd15, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1};
        tbl[4] = '{16'h4000, 2'd1, 4'd0,  3'd0, 3'd0, 3'd0, 3'd0, 1'b0};
        tbl[5] = '{16'h2A55, 2'd0, 4'd10, 3'd4, 3'd5, 3'd2, 3'd2, 1'b1};
        for (int i = 0; i < 6; i++) mem[i] = tbl[i].word;

        rst = 1'b1;
        imem_valid = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        @(negedge clk);
        #1 chk("req_in_reset", {63'h0, imem_req}, 64'h0);
        step();
        chk("reset_outs", outs(), 64'h0);
        chk("reset_addr", {48'h0, imem_addr}, 64'h0);
        rst = 1'b0;

        // Back-to-back stream: instruction k appears after edge k with pc_o = k.
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("stream_%0d", k), outs(),
                exp_outs(1'b1, 16'(k), tbl[k].fmt, tbl[k].op, tbl[k].rd, tbl[k].r1,
                         tbl[k].r2, tbl[k].imm, tbl[k].f, 16'h0000));
        end

        // Jump at 5 with extension at 6.
        mem[5] = 16'hC000;
        mem[6] = 16'h0040;
        mem[7] = 16'h2A55;
        imem_valid = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0005;
        step();
        chk("redir_valid", {63'h0, valid_o}, 64'h0);
        chk("redir_addr", {48'h0, imem_addr}, 64'h5);
        redirect_i = 1'b0;
        imem_valid = 1'b1;
        step();
        chk("jmp_first_novalid", {63'h0, valid_o}, 64'h0);
        chk("jmp_ext_addr", {48'h0, imem_addr}, 64'h6);
        step();
        chk("jmp_outs", outs(),
            exp_outs(1'b1, 16'h0005, 2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0040));
        chk("jmp_next_addr", {48'h0, imem_addr}, 64'h7);

        // Stall three cycles while the jump is presented.
        stall_i = 1'b1;
        #1 chk("stall_req", {63'h0, imem_req}, 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall_outs_%0d", c), outs(),
                exp_outs(1'b1, 16'h0005, 2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0040));
            chk($sformatf("stall_addr_req_%0d", c), {47'h0, imem_req, imem_addr}, {47'h0, 1'b0, 16'h0007});
        end
        stall_i = 1'b0;
        mem[8] = 16'hC000;
        mem[9] = 16'h1234;
        mem[16'h0100] = 16'h0483;
        step();
        chk("after_stall", outs(),
            exp_outs(1'b1, 16'h0007, 2'd0, 4'd10, 3'd4, 3'd5, 3'd2, 3'd2, 1'b1, 16'h0000));

        // Redirect while waiting for a jump extension word.
        step();
        chk("ext_wait_valid", {63'h0, valid_o}, 64'h0);
        chk("ext_wait_addr", {48'h0, imem_addr}, 64'h9);
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0100;
        #1 chk("redir_req", {63'h0, imem_req}, 64'h0);
        step();
        chk("redir_ext_valid", {63'h0, valid_o}, 64'h0);
        chk("redir_ext_addr", {48'h0, imem_addr}, 64'h0100);
        redirect_i = 1'b0;
        step();
        chk("redir_target", outs(),
            exp_outs(1'b1, 16'h0100, 2'd0, 4'd1, 3'd1, 3'd0, 3'd1, 3'd1, 1'b1, 16'h0000));

        // No transfer while valid and not stalled: output drops.
        imem_valid = 1'b0;
        step();
        chk("drain_valid", {63'h0, valid_o}, 64'h0);
        chk("drain_addr", {48'h0, imem_addr}, 64'h0101);

        // Wrap: jump at FFFF whose extension comes from 0000, after a two-cycle memory wait.
        mem[16'hFFFF] = 16'hC000;
        mem[0] = 16'hBEEF;
        redirect_i = 1'b1;
        redirect_pc_i = 16'hFFFF;
        step();
        redirect_i = 1'b0;
        chk("wrap_addr", {48'h0, imem_addr}, 64'hFFFF);
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("wait_hold_%0d", c), {47'h0, valid_o, imem_addr}, {47'h0, 1'b0, 16'hFFFF});
        end
        imem_valid = 1'b1;
        step();
        chk("wrap_ext_addr", {47'h0, valid_o, imem_addr}, {47'h0, 1'b0, 16'h0000});
        step();
        chk("wrap_jmp_outs", outs(),
            exp_outs(1'b1, 16'hFFFF, 2'd3, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'hBEEF));
        chk("wrap_next_addr", {48'h0, imem_addr}, 64'h0001);

        // Reset in a memory wait, with redirect and stall also asserted.
        imem_valid = 1'b0;
        stall_i = 1'b0;
        step();
        rst = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0300;
        stall_i = 1'b1;
        #1 chk("req_mid_reset", {63'h0, imem_req}, 64'h0);
        step();
        chk("mid_reset_outs", outs(), 64'h0);
        chk("mid_reset_addr", {48'h0, imem_addr}, 64'h0);
        rst = 1'b0;
        redirect_i = 1'b0;
        stall_i = 1'b0;
        imem_valid = 1'b1;
        mem[0] = 16'h1101;
        step();
        chk("post_reset_fetch", outs(),
            exp_outs(1'b1, 16'h0000, 2'd0, 4'd4, 3'd2, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: imem_req out 1 fetch request; imem_addr out 16 word address; imem_rdata in 16 instruction word; imem_valid in 1 transfer acknowledge.
REQ-005 SHALL have ports: stall_i in 1 downstream cannot accept; redirect_i in 1 control-flow redirect; redirect_pc_i in 16 redirect target.
REQ-006 SHALL have ports: valid_o out 1; pc_o out 16; format_o out 2; opcode_o out 4; reg1_o, reg2_o, regD_o out 3 each; imm_o out 3; immFlag_o out 1; jmpLoc_o out 16; all registered.

Function
REQ-007 SHALL treat a memory transfer as occurring in any cycle with imem_req=1 and imem_valid=1; imem_rdata is the word at imem_addr in that same cycle.
REQ-008 SHALL decode a word as format=[15:14], opcode=[13:10], regD=[9:7], reg1=[6:4], reg2=[3:1], immFlag=[0]; imm=[3:1] if immFlag=1, else 3'b000.
REQ-009 SHALL implement FSM {FETCH_OP, FETCH_EXT}; imem_addr = pc in both states.
REQ-010 SHALL drive imem_req = !redirect_i && !(valid_o && stall_i).
REQ-011 SHALL, on a FETCH_OP transfer of a non-jump word (format != 2'b11), load all decoded fields, set jmpLoc_o=16'h0000, set pc_o=pc, assert valid_o next cycle, increment pc and stay in FETCH_OP.
REQ-012 SHALL, on a FETCH_OP transfer of a jump word (format == 2'b11), load the decoded fields and pc_o, keep valid_o=0, increment pc and enter FETCH_EXT.
REQ-013 SHALL, on a FETCH_EXT transfer, load jmpLoc_o=imem_rdata, assert valid_o next cycle, increment pc and return to FETCH_OP.
REQ-014 SHALL hold all outputs and pc unchanged while valid_o=1 and stall_i=1.
REQ-015 SHALL clear valid_o when valid_o=1, stall_i=0 and no instruction completes that cycle; SHALL keep valid_o=1 with new fields when one completes; back-to-back throughput = 1 non-jump per cycle.
REQ-016 SHALL give redirect_i top priority: pc<=redirect_pc_i, state<=FETCH_OP, valid_o<=0, regardless of stall_i or state; any partially fetched jump is discarded.
REQ-017 SHALL increment pc modulo 2^16 (16'hFFFF -> 16'h0000); a jump extension word is fetched across the wrap.
REQ-018 SHALL add no latency beyond one cycle from transfer to valid_o (first word of a jump: no output).

Reset
REQ-019 SHALL, when rst=1 at a clock edge, set pc=RESET_PC, state=FETCH_OP, valid_o=0, and all field outputs, pc_o and jmpLoc_o to zero, overriding redirect_i and stall_i.
REQ-020 SHALL hold imem_req=0 during any cycle in which rst=1.

Structure
REQ-021 SHALL place the format encoding (FMT_JMP=2'b11), instruction field bit positions and the FSM state enum in shared package cpu_pkg.
REQ-022 SHALL use one combinational sub-module instr_decode (16-bit word in, decoded fields out), reused by later stages.

Verification
REQ-023 SHALL verify streaming: reset, imem_valid=1, words 0x0483,0x1101 at 0,1 -> valid_o on cycles 1,2 with pc_o=0,1, immFlag_o=1 then 1, imm_o=3'b001 then 3'b000.
REQ-024 SHALL verify jump: word 0xC000 at 5, 0x0040 at 6 -> single valid_o with format_o=2'b11, pc_o=5, jmpLoc_o=16'h0040, next fetch addr 7.
REQ-025 SHALL verify stall: stall_i=1 for 3 cycles while valid_o=1 -> outputs and imem_addr frozen, imem_req=0; release -> next instruction presented one cycle later.
REQ-026 SHALL verify redirect during FETCH_EXT with redirect_pc_i=16'h0100 -> no output for the jump, next imem_addr=16'h0100, valid_o=0 for that cycle.
REQ-027 SHALL verify wrap and memory wait: pc=16'hFFFF, imem_valid low 2 cycles -> imem_addr held at 16'hFFFF, then 16'h0000; reset asserted mid-wait -> pc=RESET_PC, valid_o=0.
